// File: rtl/demux_gather_if.sv
// demux_gather handshake bundle: upstream word port and downstream packed-bus port.
// master drives words and out_ready; slave is the gather block.
interface demux_gather_if #(
  parameter int select_bit = 2,
  parameter int data_bits  = 8
);
  localparam int N = 1 << select_bit;

  logic                  clear;
  logic                  in_valid;
  logic                  in_ready;
  logic [select_bit-1:0] in_sel;
  logic                  in_auto;
  logic [data_bits-1:0]  in_data;
  logic [N*data_bits-1:0] out_bus;
  logic [N-1:0]          lane_valid;
  logic                  out_valid;
  logic                  out_ready;
  logic                  overwrite_err;

  modport master (
    output clear, in_valid, in_sel, in_auto, in_data, out_ready,
    input  in_ready, out_bus, lane_valid, out_valid, overwrite_err
  );

  modport slave (
    input  clear, in_valid, in_sel, in_auto, in_data, out_ready,
    output in_ready, out_bus, lane_valid, out_valid, overwrite_err
  );
endinterface

// File: rtl/demux_gather.sv
// demux_gather: places one word per transfer into a lane of a packed bus and
// offers the bus downstream once every lane holds fresh data.
module demux_gather #(
  parameter int select_bit = 2,
  parameter int data_bits  = 8
) (
  input logic           clk,
  input logic           rst_n,
  demux_gather_if.slave io
);
  localparam int N = 1 << select_bit;

  typedef enum logic {
    S_FILL = 1'b0,
    S_FULL = 1'b1
  } state_t;

  state_t                  r_state;
  logic [N*data_bits-1:0]  r_bus;
  logic [N-1:0]            r_lv;
  logic [select_bit-1:0]   r_ptr;
  logic                    r_err;
  logic                    r_ov;

  logic                    w_ready;
  logic                    w_acc;
  logic [select_bit-1:0]   w_tgt;
  logic [N-1:0]            w_hit;
  logic [N-1:0]            w_lv_set;

  assign w_ready  = (r_state == S_FILL) && !io.clear;
  assign w_acc    = io.in_valid && w_ready;
  assign w_tgt    = io.in_auto ? r_ptr : io.in_sel;
  assign w_lv_set = r_lv | w_hit;

  always_comb begin
    w_hit        = '0;
    w_hit[w_tgt] = 1'b1;
  end

  // clear outranks everything but reset; out_bus data survives drains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FILL;
      r_bus   <= '0;
      r_lv    <= '0;
      r_ptr   <= '0;
      r_err   <= 1'b0;
      r_ov    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (io.clear) begin
        r_lv    <= '0;
        r_ptr   <= '0;
        r_state <= S_FILL;
        r_ov    <= 1'b0;
      end else begin
        unique case (r_state)
          S_FILL: begin
            if (w_acc) begin
              for (int i = 0; i < N; i++) begin
                if (w_hit[i])
                  r_bus[i*data_bits +: data_bits] <= io.in_data;
              end
              r_lv  <= w_lv_set;
              r_err <= |(r_lv & w_hit);
              if (io.in_auto)
                r_ptr <= r_ptr + 1'b1;
              if (&w_lv_set) begin
                r_state <= S_FULL;
                r_ov    <= 1'b1;
              end
            end
          end
          S_FULL: begin
            if (io.out_ready) begin
              r_lv    <= '0;
              r_ptr   <= '0;
              r_state <= S_FILL;
              r_ov    <= 1'b0;
            end
          end
          default: r_state <= S_FILL;
        endcase
      end
    end
  end

  assign io.in_ready      = w_ready;
  assign io.out_bus       = r_bus;
  assign io.lane_valid    = r_lv;
  assign io.out_valid     = r_ov;
  assign io.overwrite_err = r_err;
endmodule

// File: tb/tb_demux_gather.sv
// Self-checking bench for demux_gather (select_bit=2, data_bits=8).
// Drained buses are checked against a scoreboard queue of expected words.
module tb_demux_gather;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  demux_gather_if #(.select_bit(2), .data_bits(8)) dif ();

  demux_gather #(.select_bit(2), .data_bits(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (dif)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  // handshake happens on the coming posedge; check what leaves
  always @(negedge clk) begin
    if (rst_n && dif.out_valid && dif.out_ready && !dif.clear) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL drain_unexpected: got %h, queue empty", dif.out_bus);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (dif.out_bus !== e) begin
          n_bad++;
          $display("FAIL drain_bus: got %h need %h", dif.out_bus, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dif.in_valid = 1'b0;
    dif.clear    = 1'b0;
    dif.out_ready = 1'b0;
  endtask

  task automatic do_clear();
    dif.clear = 1'b1;
    tick();
    dif.clear = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    dif.in_sel  = '0;
    dif.in_auto = 1'b0;
    dif.in_data = '0;
    rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({dif.out_bus, dif.lane_valid, dif.out_valid, dif.overwrite_err} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: bus=%h lv=%b ov=%b err=%b",
               dif.out_bus, dif.lane_valid, dif.out_valid, dif.overwrite_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (dif.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready: got %b need 1", dif.in_ready);
    end
    tick();
  endtask

  task automatic test_auto_fill();
    logic [7:0] w[4];
    int errs;
    w = '{8'h11, 8'h22, 8'h33, 8'h44};
    errs = 0;
    dif.in_auto  = 1'b1;
    dif.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dif.in_data = w[i];
      if (i == 3) exp_q.push_back(32'h44332211);
      tick();
      if (dif.overwrite_err !== 1'b0) errs++;
    end
    dif.in_valid = 1'b0;
    n_cmp++;
    if (errs != 0) begin
      n_bad++;
      $display("FAIL fill_no_err: %0d pulses need 0", errs);
    end
    n_cmp++;
    if (dif.out_bus !== 32'h44332211 || dif.out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL fill_bus: bus=%h ov=%b need 44332211/1",
               dif.out_bus, dif.out_valid);
    end
    n_cmp++;
    if (dif.in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL fill_in_ready: got %b need 0", dif.in_ready);
    end
  endtask

  task automatic test_backpressure();
    dif.out_ready = 1'b0;
    dif.in_valid  = 1'b1;
    dif.in_data   = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (dif.out_bus !== 32'h44332211 || dif.lane_valid !== 4'b1111 ||
          dif.out_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL bp_hold%0d: bus=%h lv=%b ov=%b", i,
                 dif.out_bus, dif.lane_valid, dif.out_valid);
      end
    end
    dif.in_valid  = 1'b0;
    dif.out_ready = 1'b1;
    tick();
    dif.out_ready = 1'b0;
    #1;
    n_cmp++;
    if (dif.out_valid !== 1'b0 || dif.lane_valid !== 4'b0000 ||
        dif.in_ready !== 1'b1 || dif.out_bus !== 32'h44332211) begin
      n_bad++;
      $display("FAIL bp_drain: ov=%b lv=%b rdy=%b bus=%h need 0/0000/1/44332211",
               dif.out_valid, dif.lane_valid, dif.in_ready, dif.out_bus);
    end
  endtask

  task automatic test_overwrite();
    dif.in_auto  = 1'b0;
    dif.in_sel   = 2'd2;
    dif.in_valid = 1'b1;
    dif.in_data  = 8'hAA;
    tick();
    n_cmp++;
    if (dif.overwrite_err !== 1'b0 || dif.out_bus[23:16] !== 8'hAA) begin
      n_bad++;
      $display("FAIL ow_first: err=%b lane2=%h need 0/aa",
               dif.overwrite_err, dif.out_bus[23:16]);
    end
    dif.in_data = 8'hBB;
    tick();
    dif.in_valid = 1'b0;
    n_cmp++;
    if (dif.overwrite_err !== 1'b1 || dif.out_bus[23:16] !== 8'hBB ||
        dif.lane_valid !== 4'b0100 || dif.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL ow_second: err=%b lane2=%h lv=%b ov=%b need 1/bb/0100/0",
               dif.overwrite_err, dif.out_bus[23:16], dif.lane_valid,
               dif.out_valid);
    end
    tick();
    n_cmp++;
    if (dif.overwrite_err !== 1'b0) begin
      n_bad++;
      $display("FAIL ow_pulse_len: err=%b need 0", dif.overwrite_err);
    end
    do_clear();
  endtask

  task automatic test_mixed();
    logic [7:0] w[3];
    w = '{8'h03, 8'h04, 8'h05};
    dif.in_auto  = 1'b0;
    dif.in_sel   = 2'd0;
    dif.in_valid = 1'b1;
    dif.in_data  = 8'h01;
    tick();
    dif.in_auto = 1'b1;
    dif.in_data = 8'h02;
    tick();
    n_cmp++;
    if (dif.out_bus[7:0] !== 8'h02 || dif.overwrite_err !== 1'b1) begin
      n_bad++;
      $display("FAIL mix_lane0: lane0=%h err=%b need 02/1",
               dif.out_bus[7:0], dif.overwrite_err);
    end
    for (int i = 0; i < 3; i++) begin
      dif.in_data = w[i];
      if (i == 2) exp_q.push_back(32'h05040302);
      tick();
    end
    dif.in_valid = 1'b0;
    n_cmp++;
    if (dif.out_bus !== 32'h05040302 || dif.out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL mix_full: bus=%h ov=%b need 05040302/1",
               dif.out_bus, dif.out_valid);
    end
    dif.out_ready = 1'b1;
    tick();
    dif.out_ready = 1'b0;
  endtask

  task automatic test_clear();
    dif.in_auto  = 1'b1;
    dif.in_valid = 1'b1;
    dif.in_data  = 8'h61;
    tick();
    dif.in_data = 8'h62;
    tick();
    dif.in_data = 8'h99;
    dif.clear   = 1'b1;
    #1;
    n_cmp++;
    if (dif.in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_in_ready: got %b need 0", dif.in_ready);
    end
    tick();
    dif.clear    = 1'b0;
    dif.in_valid = 1'b0;
    n_cmp++;
    if (dif.lane_valid !== 4'b0000 || dif.out_bus !== 32'h05046261) begin
      n_bad++;
      $display("FAIL clr_state: lv=%b bus=%h need 0000/05046261",
               dif.lane_valid, dif.out_bus);
    end
    dif.in_valid = 1'b1;
    dif.in_data  = 8'h77;
    tick();
    dif.in_valid = 1'b0;
    n_cmp++;
    if (dif.out_bus !== 32'h05046277 || dif.lane_valid !== 4'b0001) begin
      n_bad++;
      $display("FAIL clr_next_write: bus=%h lv=%b need 05046277/0001",
               dif.out_bus, dif.lane_valid);
    end
    do_clear();
  endtask

  task automatic test_async_reset();
    dif.in_auto  = 1'b1;
    dif.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dif.in_data = 8'hA1 + 8'(i);
      if (i == 3) exp_q.push_back(32'hA4A3A2A1);
      tick();
    end
    dif.in_valid = 1'b0;
    n_cmp++;
    if (dif.out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL ar_full: ov=%b need 1", dif.out_valid);
    end
    #2;
    rst_n = 1'b0;
    // the captured bus is never transferred
    exp_q.delete();
    #1;
    n_cmp++;
    if ({dif.out_bus, dif.lane_valid, dif.out_valid, dif.overwrite_err} !== '0) begin
      n_bad++;
      $display("FAIL ar_async: bus=%h lv=%b ov=%b err=%b need all 0",
               dif.out_bus, dif.lane_valid, dif.out_valid, dif.overwrite_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (dif.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ar_in_ready: got %b need 1", dif.in_ready);
    end
    dif.in_valid = 1'b1;
    dif.in_data  = 8'h5A;
    tick();
    dif.in_valid = 1'b0;
    n_cmp++;
    if (dif.out_bus !== 32'h0000005A || dif.lane_valid !== 4'b0001) begin
      n_bad++;
      $display("FAIL ar_first_write: bus=%h lv=%b need 0000005a/0001",
               dif.out_bus, dif.lane_valid);
    end
  endtask

  initial begin
    test_reset();
    test_auto_fill();
    test_backpressure();
    test_overwrite();
    test_mixed();
    test_clear();
    test_async_reset();
    tick();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_left: %0d entries need 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
